// File: rtl/fano_out_arbiter.sv
// Per-channel FIFOs merged round-robin onto one valid/ready output stream.
// Define FANO_ARB_STATS_EN to build the saturating per-channel word counters.
module fano_out_arbiter #(
    parameter  int N_CHS      = 4,
    parameter  int DW         = 32,
    parameter  int FIFO_DEPTH = 4,
    localparam int CH_W       = (N_CHS > 1) ? $clog2(N_CHS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_CHS-1:0]      i_vld,
    input  logic [DW*N_CHS-1:0]   i_data,
    input  logic [N_CHS-1:0]      i_ch_en,
    input  logic [N_CHS-1:0]      i_ovf_clr,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DW-1:0]         o_data,
    output logic [CH_W-1:0]       o_ch,
    output logic [N_CHS-1:0]      o_overflow,
    output logic [16*N_CHS-1:0]   o_word_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [N_CHS-1:0]         nempty;
    logic [N_CHS-1:0]         wr_req;
    logic [N_CHS-1:0]         wr_acc;
    logic [N_CHS-1:0]         pop;
    logic [N_CHS-1:0]         drop;
    logic [N_CHS-1:0][DW-1:0] head;

    logic [CH_W-1:0]  rr_q, rr_d;
    logic [CH_W-1:0]  gnt;
    logic [CH_W-1:0]  idx;
    logic             gnt_vld;
    logic             load;

    logic             valid_q;
    logic [DW-1:0]    data_q;
    logic [CH_W-1:0]  ch_q;
    logic [N_CHS-1:0] ovf_q, ovf_d;

    function automatic logic [CH_W-1:0] wrap(input int v);
        return CH_W'(v % N_CHS);
    endfunction

    for (genvar c = 0; c < N_CHS; c++) begin : g_ch
        logic [DW-1:0] mem_q [FIFO_DEPTH];
        logic [AW-1:0] wptr_q;
        logic [AW-1:0] rptr_q;
        logic [CW-1:0] cnt_q, cnt_d;

        assign nempty[c] = (cnt_q != '0);
        assign wr_req[c] = i_vld[c] & i_ch_en[c];
        assign pop[c]    = load & (gnt == CH_W'(c));
        // a full FIFO still takes the word if its head leaves on this edge
        assign wr_acc[c] = wr_req[c] & ((cnt_q != CW'(FIFO_DEPTH)) | pop[c]);
        assign drop[c]   = wr_req[c] & ~wr_acc[c];
        assign head[c]   = mem_q[rptr_q];
        assign cnt_d     = cnt_q + CW'(wr_acc[c]) - CW'(pop[c]);

        always_ff @(posedge clk) begin
            if (wr_acc[c]) begin
                mem_q[wptr_q] <= i_data[DW*(c+1)-1 -: DW];
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (wr_acc[c]) begin
                    wptr_q <= wptr_q + 1'b1;
                end
                if (pop[c]) begin
                    rptr_q <= rptr_q + 1'b1;
                end
                cnt_q <= cnt_d;
            end
        end
    end

    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = 0; i < N_CHS; i++) begin
            idx = wrap(int'(rr_q) + i);
            if (!gnt_vld && nempty[idx]) begin
                gnt_vld = 1'b1;
                gnt     = idx;
            end
        end
    end

    assign load = (~valid_q | i_ready) & gnt_vld;

    always_comb begin
        rr_d  = rr_q;
        ovf_d = (ovf_q & ~i_ovf_clr) | drop;
        if (load) begin
            rr_d = (gnt == CH_W'(N_CHS - 1)) ? '0 : gnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            rr_q    <= '0;
            ovf_q   <= '0;
        end else begin
            if (load) begin
                valid_q <= 1'b1;
                data_q  <= head[gnt];
                ch_q    <= gnt;
            end else if (i_ready) begin
                valid_q <= 1'b0;
            end
            rr_q  <= rr_d;
            ovf_q <= ovf_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_ch       = ch_q;
    assign o_overflow = ovf_q;

`ifdef FANO_ARB_STATS_EN
    for (genvar c = 0; c < N_CHS; c++) begin : g_stat
        logic [15:0] wc_q, wc_d;
        logic        hit;

        assign hit  = valid_q & i_ready & (ch_q == CH_W'(c));
        assign wc_d = (hit && wc_q != 16'hFFFF) ? wc_q + 16'd1 : wc_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wc_q <= '0;
            end else begin
                wc_q <= wc_d;
            end
        end

        assign o_word_cnt[16*(c+1)-1 -: 16] = wc_q;
    end
`else
    assign o_word_cnt = '0;
`endif

endmodule

// File: tb/tb_fano_out_arbiter.sv
// Directed bench for fano_out_arbiter with a queue scoreboard.
// Expected words are queued by stimulus and popped by a negedge monitor.
module tb_fano_out_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      i_vld;
    logic [DW*N-1:0]   i_data;
    logic [N-1:0]      i_ch_en;
    logic [N-1:0]      i_ovf_clr;
    logic              o_valid;
    logic              i_ready;
    logic [DW-1:0]     o_data;
    logic [1:0]        o_ch;
    logic [N-1:0]      o_overflow;
    logic [16*N-1:0]   o_word_cnt;

    fano_out_arbiter #(.N_CHS(N), .DW(DW), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_vld      (i_vld),
        .i_data     (i_data),
        .i_ch_en    (i_ch_en),
        .i_ovf_clr  (i_ovf_clr),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_ch       (o_ch),
        .o_overflow (o_overflow),
        .o_word_cnt (o_word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_w(input int c, input logic [31:0] d);
        exp_t e;
        e.ch   = 2'(c);
        e.data = d;
        sbq.push_back(e);
    endtask

    task automatic set_ch(input int c, input logic [31:0] d);
        i_vld[c]           = 1'b1;
        i_data[32*c +: 32] = d;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || o_valid) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_queue", 64'(sbq.size()), 0);
        chk("drain_valid", 64'(o_valid), 0);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        i_vld     = '0;
        i_ovf_clr = '0;
        i_ch_en   = '1;
        i_ready   = 1'b1;
        i_data    = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    always @(negedge clk) begin
        if (reset_n && o_valid && i_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got ch%0d %08h, required no word", o_ch, o_data);
            end else begin
                mon_e = sbq.pop_front();
                if (o_ch !== mon_e.ch || o_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL sb_word: got ch%0d %08h, required ch%0d %08h",
                             o_ch, o_data, mon_e.ch, mon_e.data);
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rrw(input int c, input int j);
        return 32'hC0DE_0000 | 32'(c << 8) | 32'(j);
    endfunction

    initial begin
        do_reset();
        chk("rst_valid", 64'(o_valid), 0);
        chk("rst_data", 64'(o_data), 0);
        chk("rst_ch", 64'(o_ch), 0);
        chk("rst_ovf", 64'(o_overflow), 0);
        chk("rst_wcnt", o_word_cnt, 0);

        // single word, latency and one-cycle valid
        set_ch(2, 32'hA5A5_0001);
        expect_w(2, 32'hA5A5_0001);
        tick();
        i_vld = '0;
        chk("lat_k", 64'(o_valid), 0);
        tick();
        chk("lat_k1_valid", 64'(o_valid), 1);
        chk("lat_k1_ch", 64'(o_ch), 2);
        chk("lat_k1_data", 64'(o_data), 64'h0000_0000_A5A5_0001);
        tick();
        chk("lat_k2_valid", 64'(o_valid), 0);

        // round robin with all channels saturated
        do_reset();
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (k < 5) expect_w(c, rrw(c, k));
                else if (c < 3) expect_w(c, rrw(c, 5 + c));
            end
        end
        for (int j = 0; j < 8; j++) begin
            for (int c = 0; c < 4; c++) set_ch(c, rrw(c, j));
            tick();
            if (j == 4) chk("rr_ovf_e4", 64'(o_overflow), 64'b0000);
            if (j == 5) chk("rr_ovf_e5", 64'(o_overflow), 64'b1110);
            if (j == 7) chk("rr_ovf_e7", 64'(o_overflow), 64'b1111);
        end
        i_vld     = '0;
        i_ovf_clr = 4'hF;
        tick();
        i_ovf_clr = '0;
        chk("rr_ovf_clr", 64'(o_overflow), 0);
        drain();

        // backpressure hold, then no bubble
        i_ready = 1'b0;
        set_ch(0, 32'hB000_0000);
        set_ch(1, 32'hB000_0001);
        expect_w(0, 32'hB000_0000);
        expect_w(1, 32'hB000_0001);
        tick();
        i_vld = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(o_valid), 1);
            chk("bp_ch", 64'(o_ch), 0);
            chk("bp_data", 64'(o_data), 64'hB000_0000);
            tick();
        end
        i_ready = 1'b1;
        tick();
        chk("bp_next_valid", 64'(o_valid), 1);
        chk("bp_next_ch", 64'(o_ch), 1);
        tick();
        chk("bp_end_valid", 64'(o_valid), 0);

        // overflow: 5th write into a full FIFO is dropped
        do_reset();
        i_ready = 1'b0;
        expect_w(0, 32'h2222_0001);
        for (int w = 0; w < 4; w++) expect_w(1, 32'h1111_0000 + 32'(w));
        set_ch(0, 32'h2222_0001);
        set_ch(1, 32'h1111_0000);
        tick();
        for (int w = 1; w < 4; w++) begin
            i_vld = '0;
            set_ch(1, 32'h1111_0000 + 32'(w));
            tick();
        end
        chk("ovf1_pre", 64'(o_overflow), 0);
        set_ch(1, 32'h1111_0004);
        tick();
        i_vld = '0;
        chk("ovf1_drop", 64'(o_overflow), 64'b0010);
        i_ready = 1'b1;
        drain();
        i_ovf_clr = 4'b0010;
        tick();
        i_ovf_clr = '0;
        chk("ovf1_clr", 64'(o_overflow), 0);

        // overflow: pop on the same edge lets the 5th write in
        i_ready = 1'b0;
        expect_w(0, 32'h2222_0002);
        for (int w = 0; w < 5; w++) expect_w(1, 32'h3333_0000 + 32'(w));
        set_ch(0, 32'h2222_0002);
        set_ch(1, 32'h3333_0000);
        tick();
        for (int w = 1; w < 4; w++) begin
            i_vld = '0;
            set_ch(1, 32'h3333_0000 + 32'(w));
            tick();
        end
        set_ch(1, 32'h3333_0004);
        i_ready = 1'b1;
        tick();
        i_vld = '0;
        chk("ovf2_nodrop", 64'(o_overflow), 0);
        drain();

        // overflow: set wins over a simultaneous clear
        i_ready = 1'b0;
        expect_w(0, 32'h2222_0003);
        for (int w = 0; w < 4; w++) expect_w(1, 32'h4444_0000 + 32'(w));
        set_ch(0, 32'h2222_0003);
        set_ch(1, 32'h4444_0000);
        tick();
        for (int w = 1; w < 5; w++) begin
            i_vld = '0;
            set_ch(1, 32'h4444_0000 + 32'(w));
            tick();
        end
        chk("ovf3_set", 64'(o_overflow), 64'b0010);
        set_ch(1, 32'h4444_0005);
        i_ovf_clr = 4'b0010;
        tick();
        chk("ovf3_set_wins", 64'(o_overflow), 64'b0010);
        i_vld = '0;
        tick();
        i_ovf_clr = '0;
        chk("ovf3_clr", 64'(o_overflow), 0);
        i_ready = 1'b1;
        drain();

        // disabled channel discards input but still drains
        i_ready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            expect_w(3, 32'hD000_0000 + 32'(w));
            i_vld = '0;
            set_ch(3, 32'hD000_0000 + 32'(w));
            tick();
        end
        i_ch_en = 4'b0111;
        i_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            set_ch(3, 32'hE000_0000 + 32'(w));
            tick();
        end
        i_vld = '0;
        drain();
        chk("dis_ovf", 64'(o_overflow), 0);
        i_ch_en = '1;

        // asynchronous reset mid-burst
        i_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            for (int c = 0; c < 4; c++) set_ch(c, 32'hF000_0000 + 32'(c * 16 + j));
            tick();
        end
        chk("mid_valid_pre", 64'(o_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_async_valid", 64'(o_valid), 0);
        i_vld = '0;
        tick();
        tick();
        reset_n = 1'b1;
        i_ready = 1'b1;
        repeat (4) tick();
        chk("mid_empty_valid", 64'(o_valid), 0);
        chk("mid_data", 64'(o_data), 0);
        chk("mid_ovf", 64'(o_overflow), 0);
        expect_w(1, 32'h5555_0001);
        expect_w(3, 32'h5555_0003);
        set_ch(1, 32'h5555_0001);
        set_ch(3, 32'h5555_0003);
        tick();
        i_vld = '0;
        drain();

`ifdef FANO_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 70000; i++) begin
            expect_w(0, 32'(i));
            set_ch(0, 32'(i));
            tick();
        end
        i_vld = '0;
        drain();
        chk("stats_sat", 64'(o_word_cnt[15:0]), 64'hFFFF);
`else
        chk("stats_off", o_word_cnt, 0);
`endif

        chk("sb_left", 64'(sbq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
